dp_rr_sched: RTL and testbench

- Round-robin scheduler that shares one sequenced arithmetic datapath between NREQ requesters.
- Arbitrates requests, loads the winner's operand into the datapath and pulses its start input (w).
- Waits for the datapath done flag, then returns the result to the winner, or aborts the job on timeout.
- Sits between requester blocks and the datapath's control FSM.

---
 rtl/dp_sched_pkg.sv | 24 ++
 rtl/dp_rr_sched_rr_pick.sv | 55 +++++
 rtl/dp_rr_sched.sv | 162 ++++++++++++++++
 tb/tb_dp_rr_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_sched_pkg.sv
// dp_sched_pkg: shared definitions for the round-robin datapath scheduler.
//   - default parameter values (requester count, operand width, timeout)
//   - FSM state encoding
//   - idw(): width of a requester index, never less than one bit
package dp_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dp_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this search (0..NREQ-1)
//   found : at least one request is set
//   idx   : first set request searching ptr, ptr+1, ... mod NREQ
// The request vector is rotated so that ptr lands at bit 0, priority-encoded
// from bit 0 upwards, and the offset is added back modulo NREQ. The modular
// add handles non-power-of-2 NREQ, where a plain IDW-bit wrap would be wrong.
module rr_pick
    import dp_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;

    function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] a,
                                               input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
        return s[IDW-1:0];
    endfunction

    // rotate: rot[j] is the request that sits j places after ptr
    always_comb begin
        rot = '0;
        for (int j = 0; j < NREQ; j++) begin
            rot[j] = req[add_mod(ptr, IDW'(j))];
        end
    end

    // priority-encode: lowest set bit of the rotated vector wins
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = IDW'(j);
            end
        end
    end

    // un-rotate back to an absolute requester index
    assign idx = add_mod(ptr, off);

endmodule

// File: rtl/dp_rr_sched.sv
// dp_rr_sched: round-robin scheduler sharing one sequenced datapath between
// NREQ requesters. One job is outstanding at a time.
//   clk, rst      : clock (rising edge), async active-low reset
//   req, req_x    : per-requester request level and operand (i at [i*W +: W])
//   gnt           : one-hot grant, held from GRANT until RESP/ABORT ends
//   rsp_valid/id/data/err : one-cycle response strobe and its payload
//   dp_w, dp_x    : datapath start pulse and operand
//   dp_clr        : one-cycle datapath clear on timeout abort
//   dp_done, dp_result : datapath completion flag and result (WAIT only)
//   busy          : scheduler not idle
// All outputs except busy are registers; busy decodes the state register.
module dp_rr_sched
    import dp_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*W-1:0]      req_x,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    output logic [idw(NREQ)-1:0]   rsp_id,
    output logic [W-1:0]           rsp_data,
    output logic                   rsp_err,
    output logic                   dp_w,
    output logic [W-1:0]           dp_x,
    output logic                   dp_clr,
    input  logic                   dp_done,
    input  logic [W-1:0]           dp_result,
    output logic                   busy
);

    localparam int IDW = idw(NREQ);
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    state_t         state, state_d;
    logic [IDW-1:0] id, id_d;
    logic [IDW-1:0] ptr, ptr_d;
    logic [TW-1:0]  timer, timer_d;

    logic [NREQ-1:0] gnt_d;
    logic [W-1:0]    dp_x_d, rsp_data_d;
    logic [IDW-1:0]  rsp_id_d;
    logic            dp_w_d, dp_clr_d, rsp_valid_d, rsp_err_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [W-1:0]    xs [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_xs
        assign xs[i] = req_x[i*W +: W];
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy = (state != S_IDLE);

    // Next-state and next-output logic. Pulses default low so each lasts one
    // cycle; rsp payload is zero outside the strobe cycle.
    always_comb begin
        state_d     = state;
        id_d        = id;
        ptr_d       = ptr;
        timer_d     = timer;
        gnt_d       = gnt;
        dp_x_d      = dp_x;
        dp_w_d      = 1'b0;
        dp_clr_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_GRANT;
                    id_d    = pick_idx;
                    dp_x_d  = xs[pick_idx];
                    gnt_d   = NREQ'(1) << pick_idx;
                end
            end
            S_GRANT: begin
                state_d = S_START;
                dp_w_d  = 1'b1;
            end
            S_START: begin
                // dp_done is deliberately not looked at here
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // done has priority over the timeout on the last WAIT cycle
                if (dp_done) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id;
                    rsp_data_d  = dp_result;
                end else if (timer == T_LAST) begin
                    state_d     = S_ABORT;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id;
                    rsp_err_d   = 1'b1;
                    dp_clr_d    = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            S_RESP, S_ABORT: begin
                // the served requester drops to lowest priority next search
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = (id == ID_LAST) ? '0 : id + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            id        <= '0;
            ptr       <= '0;
            timer     <= '0;
            gnt       <= '0;
            dp_x      <= '0;
            dp_w      <= 1'b0;
            dp_clr    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            id        <= id_d;
            ptr       <= ptr_d;
            timer     <= timer_d;
            gnt       <= gnt_d;
            dp_x      <= dp_x_d;
            dp_w      <= dp_w_d;
            dp_clr    <= dp_clr_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dp_rr_sched.sv
// Scoreboard bench for dp_rr_sched: the stimulus process pushes expected
// grants and responses; a monitor on the falling edge pops and compares.
// A small datapath model returns operand + 0x25 a programmable delay after
// dp_w; requester agents hold req until their response comes back.
module tb_dp_rr_sched;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              dp_w;
    logic [W-1:0]      dp_x;
    logic              dp_clr;
    logic              dp_done;
    logic [W-1:0]      dp_result;
    logic              busy;

    dp_rr_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .dp_w(dp_w), .dp_x(dp_x), .dp_clr(dp_clr),
        .dp_done(dp_done), .dp_result(dp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] x_tab [NREQ] = '{8'h05, 8'h11, 8'h3C, 8'hF0};
    assign req_x = {x_tab[3], x_tab[2], x_tab[1], x_tab[0]};

    typedef struct { int id; logic [W-1:0] x; } gexp_t;
    typedef struct { int id; logic [W-1:0] data; logic err; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // expected data is written out by hand for each job
    task automatic push_job(input int id, input logic [W-1:0] data, input logic err);
        gq.push_back('{id, x_tab[id]});
        rq.push_back('{id, data, err});
    endtask

    // ---------------- requester agents ----------------
    int pend [NREQ] = '{default: 0};
    initial begin
        req = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && rsp_valid && pend[rsp_id] > 0) pend[rsp_id]--;
            #1;
            for (int i = 0; i < NREQ; i++) req[i] = (pend[i] > 0);
        end
    end

    // ---------------- datapath model ----------------
    bit           dp_en       = 1'b1;
    bit           start_pulse = 1'b0;
    int           dp_delay    = 10;
    int           cnt         = 0;
    logic [W-1:0] opnd        = '0;
    initial begin
        dp_done   = 1'b0;
        dp_result = '0;
        forever begin
            @(posedge clk);
            #1;
            dp_done = 1'b0;
            if (!rst) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    dp_done   = 1'b1;
                    dp_result = opnd + 8'h25;
                end
            end
            if (dp_w && dp_en) begin
                cnt  = dp_delay;
                opnd = dp_x;
                if (start_pulse) begin
                    dp_done   = 1'b1;
                    dp_result = 8'hEE;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int              cyc = 0;
        int              rise_cyc = 0, w_cyc = 0, done_cyc = 0;
        logic [NREQ-1:0] prev_gnt = '0;
        logic [W-1:0]    cur_x = '0;
        gexp_t           ge;
        rexp_t           re;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_gnt = '0;
            end else begin
                if (gnt != 0 && prev_gnt == 0) begin
                    rise_cyc = cyc;
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt), 32'd0);
                    end else begin
                        ge = gq.pop_front();
                        chk("gnt_onehot_id", 32'(gnt), 32'(1) << ge.id);
                        cur_x = ge.x;
                    end
                end else if (gnt != 0) begin
                    chk("gnt_held", 32'(gnt), 32'(prev_gnt));
                end
                if (dp_w) begin
                    w_cyc = cyc;
                    chk("dp_w_latency", 32'(cyc), 32'(rise_cyc + 1));
                    chk("dp_x", 32'(dp_x), 32'(cur_x));
                end
                if (dp_done) done_cyc = cyc;
                if (rsp_valid) begin
                    if (rq.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        re = rq.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(re.id));
                        chk("rsp_data", 32'(rsp_data), 32'(re.data));
                        chk("rsp_err", 32'(rsp_err), 32'(re.err));
                        chk("dp_clr", 32'(dp_clr), 32'(re.err));
                        chk("rsp_latency", 32'(cyc),
                            re.err ? 32'(w_cyc + TIMEOUT + 1) : 32'(done_cyc + 1));
                    end
                end else begin
                    chk("dp_clr_alone", 32'(dp_clr), 32'd0);
                end
                prev_gnt = gnt;
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #3;
            if (rq.size() == 0 && gq.size() == 0 && pend.sum() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", 32'(ok), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        // reset with all requests up; id0 asks twice -> order 0,1,2,3,0
        pend = '{2, 1, 1, 1};
        push_job(0, 8'h2A, 1'b0);
        push_job(1, 8'h36, 1'b0);
        push_job(2, 8'h61, 1'b0);
        push_job(3, 8'h15, 1'b0);
        push_job(0, 8'h2A, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_dp_w", 32'(dp_w), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_x", 32'(dp_x), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("c0_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("c1_gnt", 32'(gnt), 32'b0001);
        chk("c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("c2_dp_w", 32'(dp_w), 32'd1);
        chk("c2_dp_x", 32'(dp_x), 32'h05);
        wait_idle();

        // pointer wrap: id1 served, then 0 and 1 request -> 0 wins
        push_job(1, 8'h36, 1'b0);
        pend[1] = 1;
        wait_idle();
        push_job(0, 8'h2A, 1'b0);
        push_job(1, 8'h36, 1'b0);
        pend[0] = 1;
        pend[1] = 1;
        wait_idle();

        // timeout abort on id2, then a normal job on id3
        dp_en = 1'b0;
        push_job(2, 8'h00, 1'b1);
        pend[2] = 1;
        wait_idle();
        dp_en = 1'b1;
        push_job(3, 8'h15, 1'b0);
        pend[3] = 1;
        wait_idle();

        // done on the final WAIT cycle wins over timeout
        dp_delay = 32;
        push_job(0, 8'h2A, 1'b0);
        pend[0] = 1;
        wait_idle();

        // done pulse (with a bogus result) during START is ignored
        dp_delay    = 5;
        start_pulse = 1'b1;
        push_job(1, 8'h36, 1'b0);
        pend[1] = 1;
        wait_idle();
        start_pulse = 1'b0;

        // reset mid-WAIT on id3 (ptr=2 before); afterwards ptr must be 0
        dp_en = 1'b0;
        gq.push_back('{3, x_tab[3]});
        pend[3] = 1;
        repeat (12) @(posedge clk);
        #3;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_dp_x", 32'(dp_x), 32'd0);
        pend[3] = 0;
        pend[0] = 1;
        pend[3] = 1;
        dp_en = 1'b1;
        dp_delay = 4;
        push_job(0, 8'h2A, 1'b0);
        push_job(3, 8'h15, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        wait_idle();

        repeat (4) @(posedge clk);
        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_err);
        $fatal(1);
    end

endmodule
